// File: rtl/activation_sequencer.sv
// activation_sequencer: PL-side initiator for the activation engine. Loads a vector
// into the engine's input BRAM, launches sigmoid/tanh, waits for done, acknowledges,
// then streams the results out of the engine's output BRAM.
module activation_sequencer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BRAM_WIDTH = 32,
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned NUM_WORDS  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    // command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_func,
    output logic                  cmd_err,
    // input stream
    input  logic [BRAM_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    // result stream
    output logic [BRAM_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    // engine control/status
    output logic [31:0]           act_control,
    input  logic [31:0]           act_status,
    // engine input BRAM (write side)
    output logic [ADDR_WIDTH-1:0] bram_addr_in,
    output logic [BRAM_WIDTH-1:0] bram_wrdata_in,
    output logic [WORD_BYTES-1:0] bram_we_in,
    // engine output BRAM (read side, 1-cycle latency)
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    input  logic [BRAM_WIDTH-1:0] bram_rddata_out
);

    localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitDone,
        StAck,
        StRdAddr,
        StRdHold
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [1:0]            func_q, func_d;
    logic [BRAM_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  cmd_err_q, cmd_err_d;

    logic                  func_ok;
    logic                  idx_last;
    logic                  done;
    logic [IdxW+1:0]       byte_addr;
    logic                  unused_status;

    assign func_ok       = (cmd_func == 2'b01) || (cmd_func == 2'b10);
    assign idx_last      = (idx_q == LastIdx);
    assign done          = act_status[0];
    assign byte_addr     = {idx_q, 2'b00};
    assign unused_status = ^act_status[31:1];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            func_q    <= 2'b00;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            func_q    <= func_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Next-state logic for the load / launch / ack / unload sequence.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        func_d    = func_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        cmd_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (func_ok) begin
                        func_d  = cmd_func;
                        idx_d   = '0;
                        state_d = StLoad;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (s_valid) begin
                    if (idx_last) begin
                        state_d = StStart;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStart: begin
                // done is deliberately not sampled here
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (done) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!done) begin
                    idx_d   = '0;
                    state_d = StRdAddr;
                end
            end
            StRdAddr: begin
                state_d = StRdHold;
            end
            StRdHold: begin
                if (!m_valid_q) begin
                    // first RD_HOLD cycle: BRAM data for idx is now valid
                    m_data_d  = bram_rddata_out;
                    m_valid_d = 1'b1;
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (idx_last) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRdAddr;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode; writes are also blocked while reset is asserted.
    always_comb begin
        cmd_ready      = (state_q == StIdle);
        s_ready        = (state_q == StLoad) && !reset;
        bram_we_in     = (s_ready && s_valid) ? {WORD_BYTES{1'b1}} : {WORD_BYTES{1'b0}};
        bram_wrdata_in = s_data;
        bram_addr_in   = ADDR_WIDTH'(byte_addr);
        bram_addr_out  = ADDR_WIDTH'(byte_addr);
        // Nonzero control only while launching/running; zero during ack avoids a relaunch.
        act_control    = ((state_q == StStart) || (state_q == StWaitDone)) ? 32'(func_q) : 32'd0;
        m_data         = m_data_q;
        m_valid        = m_valid_q;
        m_last         = m_valid_q && idx_last;
        busy           = (state_q != StIdle);
        cmd_err        = cmd_err_q;
    end

endmodule

// File: tb/tb_activation_sequencer.sv
// tb_activation_sequencer: directed, table-driven bench with a small engine model
// (done after 10 active cycles, cleared once control returns to 0) and output BRAM.
module tb_activation_sequencer;

    localparam int unsigned NW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_func;
    logic        cmd_err;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic [31:0] act_control;
    logic [31:0] act_status;
    logic [11:0] bram_addr_in;
    logic [31:0] bram_wrdata_in;
    logic [3:0]  bram_we_in;
    logic [11:0] bram_addr_out;
    logic [31:0] bram_rddata_out;

    int nvec = 0;
    int nmis = 0;

    activation_sequencer #(
        .ADDR_WIDTH(12),
        .BRAM_WIDTH(32),
        .WORD_BYTES(4),
        .NUM_WORDS (NW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_func       (cmd_func),
        .cmd_err        (cmd_err),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .busy           (busy),
        .act_control    (act_control),
        .act_status     (act_status),
        .bram_addr_in   (bram_addr_in),
        .bram_wrdata_in (bram_wrdata_in),
        .bram_we_in     (bram_we_in),
        .bram_addr_out  (bram_addr_out),
        .bram_rddata_out(bram_rddata_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] s_word;
        logic [11:0] exp_addr;
        logic [31:0] rd_word;
        logic        exp_last;
    } vec_t;

    typedef struct {
        logic [1:0] func;
        logic       exp_err;
        logic       exp_busy;
    } cmd_vec_t;

    vec_t        tab[NW];
    cmd_vec_t    ctab[2];
    logic [31:0] out_mem[NW];

    // Engine model
    logic       eng_done;
    logic       force_done;
    int         eng_cnt;

    assign act_status = {31'd0, eng_done | force_done};

    always @(posedge clk) begin
        if (reset) begin
            eng_done <= 1'b0;
            eng_cnt  <= 0;
        end else if (eng_done) begin
            eng_cnt <= 0;
            if (act_control == 32'd0) eng_done <= 1'b0;
        end else if (act_control != 32'd0) begin
            if (eng_cnt == 9) eng_done <= 1'b1;
            else eng_cnt <= eng_cnt + 1;
        end else begin
            eng_cnt <= 0;
        end
    end

    always @(posedge clk) begin
        bram_rddata_out <= out_mem[bram_addr_out[3:2]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words();
        for (int i = 0; i < NW; i++) begin
            s_valid = 1'b1;
            s_data  = tab[i].s_word;
            #1;
            check("load_we", 32'(bram_we_in), 32'hF);
            check("load_addr", 32'(bram_addr_in), 32'(tab[i].exp_addr));
            check("load_wdata", bram_wrdata_in, tab[i].s_word);
            step();
        end
    endtask

    task automatic run_pass(input logic [1:0] func, input bit stall);
        int n;
        cmd_valid = 1'b1;
        cmd_func  = func;
        #1;
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("busy_load", 32'(busy), 32'd1);
        check("s_ready_load", 32'(s_ready), 32'd1);
        load_words();
        // START: stray s_valid and a premature done must both be ignored
        s_data     = 32'hdeadbeef;
        force_done = 1'b1;
        #1;
        check("start_ctrl", act_control, 32'(func));
        check("start_we", 32'(bram_we_in), 32'd0);
        check("start_s_ready", 32'(s_ready), 32'd0);
        step();
        force_done = 1'b0;
        s_valid    = 1'b0;
        check("wait_ctrl", act_control, 32'(func));
        n = 0;
        while (act_control != 32'd0 && n < 40) begin
            step();
            n++;
        end
        check("done_timeout", 32'(n < 40), 32'd1);
        check("ack_after_done", 32'(act_status[0]), 32'd1);
        check("ack_busy", 32'(busy), 32'd1);
        for (int i = 0; i < NW; i++) begin
            n = 0;
            while (!m_valid && n < 10) begin
                step();
                n++;
            end
            check("m_valid", 32'(m_valid), 32'd1);
            if (i > 0) check("rd_latency", 32'(n), 32'd2);
            check("m_data", m_data, tab[i].rd_word);
            check("m_last", 32'(m_last), 32'(tab[i].exp_last));
            if (stall && i == 1) begin
                repeat (5) begin
                    step();
                    check("stall_valid", 32'(m_valid), 32'd1);
                    check("stall_data", m_data, tab[i].rd_word);
                    check("stall_last", 32'(m_last), 32'd0);
                    check("stall_addr", 32'(bram_addr_out), 32'(tab[i].exp_addr));
                end
            end
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
        end
        check("end_busy", 32'(busy), 32'd0);
        check("end_cmd_ready", 32'(cmd_ready), 32'd1);
        check("end_m_valid", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{s_word: 32'h00000000, exp_addr: 12'd0,  rd_word: 32'h3f000000, exp_last: 1'b0};
        tab[1] = '{s_word: 32'h3f800000, exp_addr: 12'd4,  rd_word: 32'h3f38cfff, exp_last: 1'b0};
        tab[2] = '{s_word: 32'hbf800000, exp_addr: 12'd8,  rd_word: 32'h3e8e6002, exp_last: 1'b0};
        tab[3] = '{s_word: 32'h40a00000, exp_addr: 12'd12, rd_word: 32'h3f800000, exp_last: 1'b1};
        ctab[0] = '{func: 2'b11, exp_err: 1'b1, exp_busy: 1'b0};
        ctab[1] = '{func: 2'b00, exp_err: 1'b1, exp_busy: 1'b0};
        for (int i = 0; i < NW; i++) out_mem[i] = tab[i].rd_word;

        // Reset with command and data requests held active
        reset      = 1'b1;
        cmd_valid  = 1'b1;
        cmd_func   = 2'b01;
        s_valid    = 1'b1;
        s_data     = 32'hcafef00d;
        m_ready    = 1'b0;
        force_done = 1'b0;
        repeat (3) begin
            step();
            check("rst_we", 32'(bram_we_in), 32'd0);
            check("rst_ctrl", act_control, 32'd0);
        end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_addr_in", 32'(bram_addr_in), 32'd0);
        check("rst_addr_out", 32'(bram_addr_out), 32'd0);

        // Sigmoid pass with a 5-cycle stall on word 1
        run_pass(2'b01, 1'b1);

        // Illegal function codes are dropped with a one-cycle error pulse
        for (int i = 0; i < 2; i++) begin
            cmd_valid = 1'b1;
            cmd_func  = ctab[i].func;
            step();
            cmd_valid = 1'b0;
            check("cmd_err_pulse", 32'(cmd_err), 32'(ctab[i].exp_err));
            check("cmd_err_busy", 32'(busy), 32'(ctab[i].exp_busy));
            step();
            check("cmd_err_clear", 32'(cmd_err), 32'd0);
            check("cmd_err_busy2", 32'(busy), 32'd0);
        end

        // Tanh pass
        run_pass(2'b10, 1'b0);

        // Reset during WAIT_DONE aborts the pass
        cmd_valid = 1'b1;
        cmd_func  = 2'b01;
        step();
        cmd_valid = 1'b0;
        load_words();
        s_valid = 1'b0;
        step();
        step();
        check("abort_pre_ctrl", act_control, 32'd1);
        reset   = 1'b1;
        s_valid = 1'b1;
        #1;
        check("abort_rst_we", 32'(bram_we_in), 32'd0);
        step();
        check("abort_ctrl", act_control, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("abort_we", 32'(bram_we_in), 32'd0);

        // Fresh sigmoid pass after the abort
        run_pass(2'b01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
